// File: rtl/sr_latch_bank_arbiter_pkg.sv
// Shared types and constants for the SR latch bank arbiter.
// FSM state encoding and latch init masks.
package sr_bank_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_INIT_STB,
    S_INIT_HOLD,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } state_t;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] INIT_RST_MASK = '1;

endpackage

// File: rtl/sr_latch_bank_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from ptr upward, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // first requester at or after ptr wins
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sr_latch_bank_arbiter.sv
// Shares one gated SR latch bank among NREQ requesters.
// Sequences setup/strobe/hold so data never moves under En.
module sr_latch_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NREQ      = 2,
  parameter int PULSE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] set_mask,
  input  logic [NREQ*WIDTH-1:0] clr_mask,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  conflict,
  output logic                  busy,
  output logic [WIDTH-1:0]      lat_set,
  output logic [WIDTH-1:0]      lat_reset,
  output logic                  lat_en,
  input  logic [WIDTH-1:0]      lat_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  localparam logic [WIDTH-1:0] RST_ALL  = INIT_RST_MASK[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [PW-1:0]    LAST     = PW'(NREQ - 1);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] gvec;
  logic            flag;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   idx;
  logic            any;
  logic [WIDTH-1:0] set_sl;
  logic [WIDTH-1:0] clr_sl;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign set_sl = set_mask[int'(idx)*WIDTH +: WIDTH];
  assign clr_sl = clr_mask[int'(idx)*WIDTH +: WIDTH];

  // sequencer: init sweep, grant, setup, strobe, hold, ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      ack       <= '0;
      rdata     <= '0;
      conflict  <= 1'b0;
      busy      <= 1'b1;
      lat_set   <= '0;
      lat_reset <= '0;
      lat_en    <= 1'b0;
      rr_ptr    <= '0;
      gvec      <= '0;
      flag      <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (lat_reset != RST_ALL) begin
            lat_reset <= RST_ALL;
          end else begin
            lat_en <= 1'b1;
            cnt    <= CNT_LOAD;
            state  <= S_INIT_STB;
          end
        end
        S_INIT_STB: begin
          if (cnt == '0) begin
            lat_en <= 1'b0;
            state  <= S_INIT_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_INIT_HOLD: begin
          lat_reset <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          if (any) begin
            gvec      <= grant;
            rr_ptr    <= (idx == LAST) ? '0 : idx + 1'b1;
            flag      <= |(set_sl & clr_sl);
            lat_set   <= set_sl & ~clr_sl;
            lat_reset <= clr_sl & ~set_sl;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          lat_en <= 1'b1;
          cnt    <= CNT_LOAD;
          state  <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt == '0) begin
            lat_en <= 1'b0;
            state  <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          rdata     <= lat_q;
          ack       <= gvec;
          conflict  <= flag;
          lat_set   <= '0;
          lat_reset <= '0;
          state     <= S_ACK;
        end
        S_ACK: begin
          ack      <= '0;
          conflict <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
